// File: rtl/tt_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tt_seq_pkg
//  Description : Shared types and helpers for the TT slot sequencer.
//                - seq_state_t : sequencer FSM state encoding
//                - TT_BYTE_W   : width of one TT pad byte
//                - onehot()    : index -> one-hot vector (zero if out of range)
//  Revision    : 1.0 - initial release
// ============================================================================
package tt_seq_pkg;

    localparam int TT_BYTE_W = 8;
    localparam int MAX_SLOTS = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_RESET   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ACTIVE  = 3'd4
    } seq_state_t;

    // Callers narrow the result with a size cast; any index beyond the
    // caller's slot count therefore yields an all-zero vector.
    function automatic logic [MAX_SLOTS-1:0] onehot(input logic [31:0] idx);
        onehot = MAX_SLOTS'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_pad_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tt_pad_mux
//  Description : Registered N:1 mux from per-slot outputs to the shared pads.
//                When gate is low every pad output and enable registers 0.
//  Ports       : clk, rst            clock, async active-high reset
//                gate                1 = connect selected slot on next edge
//                sel                 selected slot index
//                slot_uo_out/uio_out/uio_oe   per-slot sources, 8 bits each
//                uo_out/uo_oe/uio_out/uio_oe  registered pad outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_pad_mux
    import tt_seq_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int IDX_W     = $clog2(NUM_SLOTS) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           gate,
    input  logic [IDX_W-1:0]               sel,
    input  logic [NUM_SLOTS*TT_BYTE_W-1:0] slot_uo_out,
    input  logic [NUM_SLOTS*TT_BYTE_W-1:0] slot_uio_out,
    input  logic [NUM_SLOTS*TT_BYTE_W-1:0] slot_uio_oe,
    output logic [TT_BYTE_W-1:0]           uo_out,
    output logic [TT_BYTE_W-1:0]           uo_oe,
    output logic [TT_BYTE_W-1:0]           uio_out,
    output logic [TT_BYTE_W-1:0]           uio_oe
);

    logic [TT_BYTE_W-1:0] w_uo_out;
    logic [TT_BYTE_W-1:0] w_uio_out;
    logic [TT_BYTE_W-1:0] w_uio_oe;

    // Compare-and-select keeps an out-of-range index from reading past the
    // packed vectors.
    always_comb begin
        w_uo_out  = '0;
        w_uio_out = '0;
        w_uio_oe  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (sel == IDX_W'(i)) begin
                w_uo_out  = slot_uo_out[i*TT_BYTE_W +: TT_BYTE_W];
                w_uio_out = slot_uio_out[i*TT_BYTE_W +: TT_BYTE_W];
                w_uio_oe  = slot_uio_oe[i*TT_BYTE_W +: TT_BYTE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uo_out  <= '0;
            uo_oe   <= '0;
            uio_out <= '0;
            uio_oe  <= '0;
        end else if (gate) begin
            uo_out  <= w_uo_out;
            uo_oe   <= {TT_BYTE_W{1'b1}};
            uio_out <= w_uio_out;
            uio_oe  <= w_uio_oe;
        end else begin
            uo_out  <= '0;
            uo_oe   <= '0;
            uio_out <= '0;
            uio_oe  <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tt_slot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tt_slot_sequencer
//  Description : Time-shares the fabric user-IO pads between NUM_SLOTS TT
//                project wrappers. A host select drains the pads, holds the
//                new slot in reset, releases it, then reconnects the pads.
//  Ports       : clk, rst                  clock, async active-high reset
//                sel_valid/sel_ready/sel_idx   host select handshake
//                ui_in, uio_in             pad input bytes
//                uo_out/uo_oe/uio_out/uio_oe   registered pad outputs
//                slot_ui_in/slot_uio_in    per-slot inputs (gated by ENA)
//                slot_uo_out/uio_out/uio_oe    per-slot outputs
//                slot_ena, slot_rst_n      per-slot enable / active-low reset
//                active_valid, active_idx  current connection status
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_slot_sequencer
    import tt_seq_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int IDX_W        = $clog2(NUM_SLOTS) + 1,
    parameter int DRAIN_CYCLES = 2,
    parameter int RST_CYCLES   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sel_valid,
    output logic                           sel_ready,
    input  logic [IDX_W-1:0]               sel_idx,
    input  logic [TT_BYTE_W-1:0]           ui_in,
    input  logic [TT_BYTE_W-1:0]           uio_in,
    output logic [TT_BYTE_W-1:0]           uo_out,
    output logic [TT_BYTE_W-1:0]           uo_oe,
    output logic [TT_BYTE_W-1:0]           uio_out,
    output logic [TT_BYTE_W-1:0]           uio_oe,
    output logic [NUM_SLOTS*TT_BYTE_W-1:0] slot_ui_in,
    output logic [NUM_SLOTS*TT_BYTE_W-1:0] slot_uio_in,
    input  logic [NUM_SLOTS*TT_BYTE_W-1:0] slot_uo_out,
    input  logic [NUM_SLOTS*TT_BYTE_W-1:0] slot_uio_out,
    input  logic [NUM_SLOTS*TT_BYTE_W-1:0] slot_uio_oe,
    output logic [NUM_SLOTS-1:0]           slot_ena,
    output logic [NUM_SLOTS-1:0]           slot_rst_n,
    output logic                           active_valid,
    output logic [IDX_W-1:0]               active_idx
);

    localparam int C_MAX_CYC = (DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES;
    localparam int C_CNT_W   = $clog2(C_MAX_CYC + 1);
    localparam logic [C_CNT_W-1:0] C_DRAIN_LOAD = C_CNT_W'(DRAIN_CYCLES);
    localparam logic [C_CNT_W-1:0] C_RST_LOAD   = C_CNT_W'(RST_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST   = C_CNT_W'(1);
    localparam logic [IDX_W-1:0]   C_NUM_SLOTS  = IDX_W'(NUM_SLOTS);

    seq_state_t             r_state, w_state_nxt;
    logic [C_CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]       r_target, w_target_nxt;
    logic [IDX_W-1:0]       r_active_idx, w_active_idx_nxt;
    logic [NUM_SLOTS-1:0]   r_ena, w_ena_nxt;
    logic [NUM_SLOTS-1:0]   r_rst_n, w_rst_n_nxt;
    logic [NUM_SLOTS-1:0]   w_target_oh;
    logic                   w_cnt_done;

    assign w_target_oh = NUM_SLOTS'(onehot(32'(r_target)));
    // <= rather than == so a zero count can never stall or wrap.
    assign w_cnt_done  = (r_cnt <= C_CNT_LAST);

    assign sel_ready    = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
    assign active_valid = (r_state == ST_ACTIVE);
    assign active_idx   = r_active_idx;
    assign slot_ena     = r_ena;
    assign slot_rst_n   = r_rst_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_target     <= '0;
            r_active_idx <= '0;
            r_ena        <= '0;
            r_rst_n      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_target     <= w_target_nxt;
            r_active_idx <= w_active_idx_nxt;
            r_ena        <= w_ena_nxt;
            r_rst_n      <= w_rst_n_nxt;
        end
    end

    // ENA/RST_N are updated on the transition edges so the old slot keeps
    // its enable and reset state untouched throughout DRAIN.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_target_nxt     = r_target;
        w_active_idx_nxt = r_active_idx;
        w_ena_nxt        = r_ena;
        w_rst_n_nxt      = r_rst_n;
        case (r_state)
            ST_IDLE, ST_ACTIVE: begin
                if (sel_valid) begin
                    w_state_nxt  = ST_DRAIN;
                    w_cnt_nxt    = C_DRAIN_LOAD;
                    w_target_nxt = sel_idx;
                end
            end
            ST_DRAIN: begin
                if (!w_cnt_done) begin
                    w_cnt_nxt = r_cnt - C_CNT_LAST;
                end else if (r_target < C_NUM_SLOTS) begin
                    w_state_nxt      = ST_RESET;
                    w_cnt_nxt        = C_RST_LOAD;
                    w_active_idx_nxt = r_target;
                    w_ena_nxt        = w_target_oh;
                    w_rst_n_nxt      = '0;
                end else begin
                    w_state_nxt      = ST_IDLE;
                    w_active_idx_nxt = '0;
                    w_ena_nxt        = '0;
                    w_rst_n_nxt      = '0;
                end
            end
            ST_RESET: begin
                if (!w_cnt_done) begin
                    w_cnt_nxt = r_cnt - C_CNT_LAST;
                end else begin
                    w_state_nxt = ST_RELEASE;
                    w_rst_n_nxt = w_target_oh;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_ACTIVE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Gate on the next state so the registered pads are zero for every
    // cycle spent outside ACTIVE, including the first DRAIN cycle.
    tt_pad_mux #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) u_pad_mux (
        .clk          (clk),
        .rst          (rst),
        .gate         (w_state_nxt == ST_ACTIVE),
        .sel          (r_active_idx),
        .slot_uo_out  (slot_uo_out),
        .slot_uio_out (slot_uio_out),
        .slot_uio_oe  (slot_uio_oe),
        .uo_out       (uo_out),
        .uo_oe        (uo_oe),
        .uio_out      (uio_out),
        .uio_oe       (uio_oe)
    );

    // Only the enabled slot sees pad inputs; the rest are held at zero.
    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot_in
            assign slot_ui_in[i*TT_BYTE_W +: TT_BYTE_W]  = r_ena[i] ? ui_in  : '0;
            assign slot_uio_in[i*TT_BYTE_W +: TT_BYTE_W] = r_ena[i] ? uio_in : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tt_slot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tt_slot_sequencer
//  Description : Randomized self-checking bench for tt_slot_sequencer. The
//                reference model records when a select was accepted and
//                derives the expected phase from elapsed cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_slot_sequencer;

    localparam int NS = 4;
    localparam int IW = 3;
    localparam int D  = 2;
    localparam int R  = 16;

    localparam int P_IDLE    = 0;
    localparam int P_DRAIN   = 1;
    localparam int P_RESET   = 2;
    localparam int P_RELEASE = 3;
    localparam int P_ACTIVE  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            sel_valid;
    logic            sel_ready;
    logic [IW-1:0]   sel_idx;
    logic [7:0]      ui_in, uio_in;
    logic [7:0]      uo_out, uo_oe, uio_out, uio_oe;
    logic [NS*8-1:0] slot_ui_in, slot_uio_in;
    logic [NS*8-1:0] slot_uo_out, slot_uio_out, slot_uio_oe;
    logic [NS-1:0]   slot_ena, slot_rst_n;
    logic            active_valid;
    logic [IW-1:0]   active_idx;

    always #5 clk = ~clk;

    tt_slot_sequencer #(
        .NUM_SLOTS    (NS),
        .IDX_W        (IW),
        .DRAIN_CYCLES (D),
        .RST_CYCLES   (R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sel_valid    (sel_valid),
        .sel_ready    (sel_ready),
        .sel_idx      (sel_idx),
        .ui_in        (ui_in),
        .uio_in       (uio_in),
        .uo_out       (uo_out),
        .uo_oe        (uo_oe),
        .uio_out      (uio_out),
        .uio_oe       (uio_oe),
        .slot_ui_in   (slot_ui_in),
        .slot_uio_in  (slot_uio_in),
        .slot_uo_out  (slot_uo_out),
        .slot_uio_out (slot_uio_out),
        .slot_uio_oe  (slot_uio_oe),
        .slot_ena     (slot_ena),
        .slot_rst_n   (slot_rst_n),
        .active_valid (active_valid),
        .active_idx   (active_idx)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: edge count, edge of last acceptance, its target and the slot
    // that was live when it was accepted (NS or above = none).
    int e     = 0;
    int m_a   = -100000;
    int m_tgt = NS;
    int m_old = NS;
    bit force_oe = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic logic [NS-1:0] oh(input int i);
        logic [NS-1:0] v;
        v = '0;
        if (i >= 0 && i < NS) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int phase();
        int k;
        k = e - m_a;
        if (k < D)               return P_DRAIN;
        if (m_tgt >= NS)         return P_IDLE;
        if (k < D + R)           return P_RESET;
        if (k == D + R)          return P_RELEASE;
        return P_ACTIVE;
    endfunction

    task automatic model_reset();
        m_a   = -100000;
        m_tgt = NS;
        m_old = NS;
    endtask

    task automatic check_all();
        int p;
        logic [NS-1:0]   x_ena, x_rn;
        logic [7:0]      x_uo, x_uoe, x_uio, x_uioe;
        logic [NS*8-1:0] x_ui, x_uioin;
        p = phase();
        x_ena = '0; x_rn = '0;
        x_uo = '0; x_uoe = '0; x_uio = '0; x_uioe = '0;
        case (p)
            P_DRAIN:   begin x_ena = oh(m_old); x_rn = oh(m_old); end
            P_RESET:   begin x_ena = oh(m_tgt); end
            P_RELEASE: begin x_ena = oh(m_tgt); x_rn = oh(m_tgt); end
            P_ACTIVE: begin
                x_ena  = oh(m_tgt);
                x_rn   = oh(m_tgt);
                x_uo   = slot_uo_out[m_tgt*8 +: 8];
                x_uoe  = 8'hFF;
                x_uio  = slot_uio_out[m_tgt*8 +: 8];
                x_uioe = slot_uio_oe[m_tgt*8 +: 8];
            end
            default: ;
        endcase
        for (int i = 0; i < NS; i++) begin
            x_ui[i*8 +: 8]    = x_ena[i] ? ui_in  : 8'h00;
            x_uioin[i*8 +: 8] = x_ena[i] ? uio_in : 8'h00;
        end
        check_eq("sel_ready",    64'(sel_ready),    64'(p == P_IDLE || p == P_ACTIVE));
        check_eq("active_valid", 64'(active_valid), 64'(p == P_ACTIVE));
        check_eq("slot_ena",     64'(slot_ena),     64'(x_ena));
        check_eq("slot_rst_n",   64'(slot_rst_n),   64'(x_rn));
        check_eq("uo_out",       64'(uo_out),       64'(x_uo));
        check_eq("uo_oe",        64'(uo_oe),        64'(x_uoe));
        check_eq("uio_out",      64'(uio_out),      64'(x_uio));
        check_eq("uio_oe",       64'(uio_oe),       64'(x_uioe));
        check_eq("slot_ui_in",   64'(slot_ui_in),   64'(x_ui));
        check_eq("slot_uio_in",  64'(slot_uio_in),  64'(x_uioin));
        if (x_ena != '0)
            check_eq("active_idx", 64'(active_idx), 64'((p == P_DRAIN) ? m_old : m_tgt));
    endtask

    task automatic randomize_data();
        ui_in        = 8'($urandom);
        uio_in       = 8'($urandom);
        slot_uo_out  = ($urandom);
        slot_uio_out = ($urandom);
        slot_uio_oe  = ($urandom);
        if (force_oe) slot_uio_oe[2*8 +: 8] = 8'h0F;
    endtask

    // One clock: predict acceptance, advance, check, then new pad/slot data.
    task automatic step(output bit acc);
        int p, idx;
        p   = phase();
        acc = sel_valid && (p == P_IDLE || p == P_ACTIVE);
        idx = int'(sel_idx);
        @(posedge clk);
        #1;
        e++;
        if (acc) begin
            m_old = m_tgt;
            m_tgt = idx;
            m_a   = e;
        end
        check_all();
        randomize_data();
    endtask

    task automatic run(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic req(input int idx);
        bit a;
        bit done;
        done      = 1'b0;
        sel_valid = 1'b1;
        sel_idx   = IW'(idx);
        for (int n = 0; n < 200 && !done; n++) begin
            step(a);
            done = a;
        end
        sel_valid = 1'b0;
        if (!done) check_eq("req_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        bit a;
        bit hit;
        rst       = 1'b1;
        sel_valid = 1'b0;
        sel_idx   = '0;
        randomize_data();
        #2;
        check_all();
        check_eq("rst_active_idx", 64'(active_idx), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run(3);

        // Select slot 2, which drives uio_oe=0F once connected.
        force_oe = 1'b1;
        randomize_data();
        req(2);
        run(D + R + 6);

        // Switch 2 -> 1, then hold a request for 3 through its RESET phase.
        req(1);
        run(D + 4);
        req(3);
        run(8);
        force_oe = 1'b0;

        // Deselect all.
        req(NS);
        run(6);

        // Async reset in the 7th RESET cycle, then restart.
        req(0);
        hit = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            if (phase() == P_RESET && (e - m_a) == D + 6) hit = 1'b1;
            else step(a);
        end
        if (!hit) check_eq("reset_point_timeout", 64'd0, 64'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check_eq("midseq_active_idx", 64'(active_idx), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        req(3);
        run(D + R + 4);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            sel_valid = ($urandom_range(0, 7) == 0);
            sel_idx   = IW'($urandom_range(0, 5));
            step(a);
        end
        sel_valid = 1'b0;
        run(D + R + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
